// File: rtl/id_stage_pkg.sv
// id_stage_pkg: opcode/funct constants, ALU op encodings and bus widths for the decode stage.
package id_stage_pkg;
  localparam int REG_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2a;
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_LUI = 4'd7
  } aluop_t;
  function automatic aluop_t funct_aluop(input logic [5:0] fn);
    return fn == FN_ADDU ? ALU_ADD :
           fn == FN_SUBU ? ALU_SUB :
           fn == FN_AND  ? ALU_AND :
           fn == FN_OR   ? ALU_OR  :
           fn == FN_XOR  ? ALU_XOR :
           fn == FN_SLT  ? ALU_SLT : ALU_NOP;
  endfunction
endpackage

// File: rtl/id_stage_fwd_mux.sv
// id_fwd_mux: per-port operand select (zero / EX forward / MEM forward / regfile).
module id_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              re,
  input  logic [REG_AW-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data
);
  assign data = (!re || raddr == '0)             ? '0 :
                (ex_we && ex_waddr == raddr)     ? ex_wdata :
                (mem_we && mem_waddr == raddr)   ? mem_wdata : rdata;
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS-subset decode, EX/MEM forwarding, load-use detection and ID/EX register.
// Optional ID_ILLEGAL_TRAP_EN adds a registered ex_illegal flag for undecodable words.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [DATA_W-1:0] if_inst,
  output logic              re1,
  output logic [REG_AW-1:0] raddr1,
  input  logic [DATA_W-1:0] rdata1,
  output logic              re2,
  output logic [REG_AW-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              fwd_ex_we,
  input  logic [REG_AW-1:0] fwd_ex_waddr,
  input  logic [DATA_W-1:0] fwd_ex_wdata,
  input  logic              fwd_ex_load,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_waddr,
  input  logic [DATA_W-1:0] fwd_mem_wdata,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stall_req,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [3:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [REG_AW-1:0] ex_waddr,
  output logic              ex_we,
  output logic              ex_is_load
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic              ex_illegal
`endif
);
  logic [5:0] op, funct;
  logic [15:0] imm;
  aluop_t d_op;
  logic [DATA_W-1:0] d_imm, op1, op2;
  logic [REG_AW-1:0] d_waddr;
  logic d_re1, d_re2, d_we, d_load, d_illegal, bubble;
  assign op = if_inst[31:26];
  assign funct = if_inst[5:0];
  assign imm = if_inst[15:0];
  assign d_op = op == OP_SPECIAL ? funct_aluop(funct) :
                op == OP_ORI     ? ALU_OR  :
                op == OP_ANDI    ? ALU_AND :
                (op == OP_ADDIU || op == OP_LW) ? ALU_ADD :
                op == OP_LUI     ? ALU_LUI : ALU_NOP;
  assign d_imm = op == OP_LUI ? {imm, {(DATA_W-16){1'b0}}} :
                 (op == OP_ORI || op == OP_ANDI) ? {{(DATA_W-16){1'b0}}, imm} :
                 {{(DATA_W-16){imm[15]}}, imm};
  assign d_re1 = d_op != ALU_NOP;
  assign d_re2 = d_re1 && op == OP_SPECIAL;
  assign d_waddr = op == OP_SPECIAL ? if_inst[15:11] : if_inst[20:16];
  assign d_we = d_re1 && d_waddr != '0;
  assign d_load = op == OP_LW;
  // the all-zero word is the canonical NOP, not an illegal encoding
  assign d_illegal = d_op == ALU_NOP && if_inst != '0;
  assign re1 = if_valid && d_re1;
  assign re2 = if_valid && d_re2;
  assign raddr1 = if_inst[25:21];
  assign raddr2 = if_inst[20:16];
  assign stall_req = fwd_ex_load && fwd_ex_we && fwd_ex_waddr != '0 &&
                     ((re1 && fwd_ex_waddr == raddr1) || (re2 && fwd_ex_waddr == raddr2));
  assign bubble = flush || (!stall_in && stall_req);
  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .re(re1), .raddr(raddr1), .rdata(rdata1),
    .ex_we(fwd_ex_we), .ex_waddr(fwd_ex_waddr), .ex_wdata(fwd_ex_wdata),
    .mem_we(fwd_mem_we), .mem_waddr(fwd_mem_waddr), .mem_wdata(fwd_mem_wdata),
    .data(op1)
  );
  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .re(re2), .raddr(raddr2), .rdata(rdata2),
    .ex_we(fwd_ex_we), .ex_waddr(fwd_ex_waddr), .ex_wdata(fwd_ex_wdata),
    .mem_we(fwd_mem_we), .mem_waddr(fwd_mem_waddr), .mem_wdata(fwd_mem_wdata),
    .data(op2)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_aluop <= ALU_NOP;
      ex_reg1 <= '0;
      ex_reg2 <= '0;
      ex_waddr <= '0;
      ex_we <= 1'b0;
      ex_is_load <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      ex_illegal <= 1'b0;
`endif
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_aluop <= ALU_NOP;
      ex_we <= 1'b0;
      ex_is_load <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      ex_illegal <= 1'b0;
`endif
    end else if (!stall_in) begin
      ex_valid <= if_valid;
      ex_pc <= if_pc;
      ex_aluop <= d_op;
      ex_reg1 <= op1;
      ex_reg2 <= d_re2 ? op2 : d_imm;
      ex_waddr <= d_waddr;
      ex_we <= d_we && if_valid;
      ex_is_load <= d_load && if_valid;
`ifdef ID_ILLEGAL_TRAP_EN
      ex_illegal <= d_illegal && if_valid;
`endif
    end
  end
`ifndef ID_ILLEGAL_TRAP_EN
  logic unused_illegal;
  assign unused_illegal = d_illegal;
`endif
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
module tb_id_stage;
  import id_stage_pkg::*;
  logic clk = 1'b0, rst;
  logic if_valid;
  logic [31:0] if_pc, if_inst, rdata1, rdata2;
  logic re1, re2, stall_req;
  logic [4:0] raddr1, raddr2;
  logic fwd_ex_we, fwd_ex_load, fwd_mem_we;
  logic [4:0] fwd_ex_waddr, fwd_mem_waddr;
  logic [31:0] fwd_ex_wdata, fwd_mem_wdata;
  logic stall_in, flush;
  logic ex_valid, ex_we, ex_is_load;
  logic [31:0] ex_pc, ex_reg1, ex_reg2;
  logic [3:0] ex_aluop;
  logic [4:0] ex_waddr;
`ifdef ID_ILLEGAL_TRAP_EN
  logic ex_illegal;
`endif
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_waddr(fwd_ex_waddr), .fwd_ex_wdata(fwd_ex_wdata),
    .fwd_ex_load(fwd_ex_load), .fwd_mem_we(fwd_mem_we), .fwd_mem_waddr(fwd_mem_waddr),
    .fwd_mem_wdata(fwd_mem_wdata), .stall_in(stall_in), .flush(flush), .stall_req(stall_req),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_reg1(ex_reg1),
    .ex_reg2(ex_reg2), .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_is_load(ex_is_load)
`ifdef ID_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd;
    fwd_ex_we = 0; fwd_ex_waddr = 0; fwd_ex_wdata = 0; fwd_ex_load = 0;
    fwd_mem_we = 0; fwd_mem_waddr = 0; fwd_mem_wdata = 0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    n_cmp++; if (ex_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", ex_we); end
    n_cmp++; if (ex_aluop !== 4'd0) begin n_err++; $display("FAIL reset_aluop got %0d exp 0", ex_aluop); end
    tick;
    rst = 0;
  endtask

  task automatic test_ori;
    if_valid = 1; if_pc = 32'h100; if_inst = itype(6'h0d, 5'd1, 5'd2, 16'h00ff); rdata1 = 32'h12340000;
    #1;
    n_cmp++; if ({re1, re2, raddr1} !== {1'b1, 1'b0, 5'd1}) begin n_err++; $display("FAIL ori_re got %b%b/%0d exp 10/1", re1, re2, raddr1); end
    tick;
    n_cmp++; if (ex_reg1 !== 32'h12340000) begin n_err++; $display("FAIL ori_reg1 got %h exp 12340000", ex_reg1); end
    n_cmp++; if (ex_reg2 !== 32'h000000ff) begin n_err++; $display("FAIL ori_reg2 got %h exp 000000ff", ex_reg2); end
    n_cmp++; if ({ex_valid, ex_we, ex_waddr} !== {1'b1, 1'b1, 5'd2}) begin n_err++; $display("FAIL ori_dst got %b%b/%0d exp 11/2", ex_valid, ex_we, ex_waddr); end
    n_cmp++; if (ex_aluop !== 4'd4 || ex_pc !== 32'h100) begin n_err++; $display("FAIL ori_op got %0d/%h exp 4/100", ex_aluop, ex_pc); end
  endtask

  task automatic test_fwd;
    if_inst = rtype(5'd1, 5'd2, 5'd3, 6'h21); rdata1 = 32'haaaa; rdata2 = 32'h7;
    fwd_ex_we = 1; fwd_ex_waddr = 1; fwd_ex_wdata = 32'h5;
    fwd_mem_we = 1; fwd_mem_waddr = 1; fwd_mem_wdata = 32'h9;
    tick;
    n_cmp++; if (ex_reg1 !== 32'h5) begin n_err++; $display("FAIL fwd_ex_prio got %h exp 5", ex_reg1); end
    n_cmp++; if (ex_reg2 !== 32'h7) begin n_err++; $display("FAIL fwd_rf2 got %h exp 7", ex_reg2); end
    n_cmp++; if ({ex_aluop, ex_waddr} !== {4'd1, 5'd3}) begin n_err++; $display("FAIL addu_dec got %0d/%0d exp 1/3", ex_aluop, ex_waddr); end
    fwd_ex_we = 0; fwd_mem_waddr = 2; fwd_mem_wdata = 32'h7; rdata1 = 32'h11; rdata2 = 32'hbbbb;
    tick;
    n_cmp++; if ({ex_reg1, ex_reg2} !== {32'h11, 32'h7}) begin n_err++; $display("FAIL fwd_mem got %h/%h exp 11/7", ex_reg1, ex_reg2); end
    if_inst = rtype(5'd0, 5'd2, 5'd3, 6'h21); fwd_ex_we = 1; fwd_ex_waddr = 0; fwd_ex_wdata = 32'hdead; rdata1 = 32'hffff;
    tick;
    n_cmp++; if (ex_reg1 !== 32'h0) begin n_err++; $display("FAIL fwd_r0 got %h exp 0", ex_reg1); end
    clear_fwd;
  endtask

  task automatic test_load_use;
    if_inst = rtype(5'd4, 5'd0, 5'd5, 6'h21); rdata1 = 32'h0; rdata2 = 32'h0;
    fwd_ex_we = 1; fwd_ex_waddr = 4; fwd_ex_load = 1; fwd_ex_wdata = 32'h0;
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", stall_req); end
    tick;
    n_cmp++; if ({ex_valid, ex_we} !== 2'b00) begin n_err++; $display("FAIL lu_bubble got %b%b exp 00", ex_valid, ex_we); end
    if_valid = 0;
    #1;
    n_cmp++; if ({stall_req, re1, re2} !== 3'b000) begin n_err++; $display("FAIL lu_invalid got %b%b%b exp 000", stall_req, re1, re2); end
    if_valid = 1; if_inst = rtype(5'd0, 5'd4, 5'd5, 6'h21);
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL lu_port2 got %b exp 1", stall_req); end
    if_inst = itype(6'h0d, 5'd1, 5'd4, 16'h1);
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL lu_imm_rt got %b exp 0", stall_req); end
    if_inst = rtype(5'd4, 5'd0, 5'd5, 6'h21);
    fwd_ex_we = 0; fwd_ex_load = 0; fwd_mem_we = 1; fwd_mem_waddr = 4; fwd_mem_wdata = 32'h44;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL lu_clear got %b exp 0", stall_req); end
    tick;
    n_cmp++; if ({ex_reg1, ex_reg2} !== {32'h44, 32'h0}) begin n_err++; $display("FAIL lu_issue got %h/%h exp 44/0", ex_reg1, ex_reg2); end
    n_cmp++; if ({ex_valid, ex_we, ex_waddr} !== {1'b1, 1'b1, 5'd5}) begin n_err++; $display("FAIL lu_dst got %b%b/%0d exp 11/5", ex_valid, ex_we, ex_waddr); end
    clear_fwd;
  endtask

  task automatic test_stall_flush;
    if_inst = itype(6'h09, 5'd1, 5'd6, 16'hffff); rdata1 = 32'h10;
    tick;
    n_cmp++; if ({ex_reg2, ex_aluop} !== {32'hffffffff, 4'd1}) begin n_err++; $display("FAIL addiu got %h/%0d exp ffffffff/1", ex_reg2, ex_aluop); end
    stall_in = 1; if_inst = itype(6'h0d, 5'd1, 5'd7, 16'h1); rdata1 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if ({ex_valid, ex_reg1, ex_reg2, ex_waddr} !== {1'b1, 32'h10, 32'hffffffff, 5'd6}) begin n_err++; $display("FAIL hold%0d got %b/%h/%h/%0d exp 1/10/ffffffff/6", i, ex_valid, ex_reg1, ex_reg2, ex_waddr); end
    end
    flush = 1;
    tick;
    n_cmp++; if ({ex_valid, ex_we} !== 2'b00) begin n_err++; $display("FAIL flush got %b%b exp 00", ex_valid, ex_we); end
    flush = 0; stall_in = 0;
  endtask

  task automatic test_illegal;
    if_inst = 32'hfc000000;
    #1;
    n_cmp++; if ({re1, re2} !== 2'b00) begin n_err++; $display("FAIL ill_re got %b%b exp 00", re1, re2); end
    tick;
    n_cmp++; if ({ex_valid, ex_we, ex_aluop} !== {1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL ill_nop got %b%b/%0d exp 10/0", ex_valid, ex_we, ex_aluop); end
`ifdef ID_ILLEGAL_TRAP_EN
    n_cmp++; if (ex_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got %b exp 1", ex_illegal); end
`endif
    if_inst = rtype(5'd1, 5'd2, 5'd3, 6'h3f);
    tick;
    n_cmp++; if (ex_we !== 1'b0) begin n_err++; $display("FAIL ill_funct got %b exp 0", ex_we); end
    if_inst = itype(6'h0d, 5'd1, 5'd2, 16'h1);
    tick;
`ifdef ID_ILLEGAL_TRAP_EN
    n_cmp++; if (ex_illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear got %b exp 0", ex_illegal); end
`endif
    n_cmp++; if (ex_we !== 1'b1) begin n_err++; $display("FAIL ill_after got %b exp 1", ex_we); end
  endtask

  task automatic test_lw_lui;
    if_inst = itype(6'h23, 5'd1, 5'd7, 16'hfffc); rdata1 = 32'h1000;
    tick;
    n_cmp++; if ({ex_is_load, ex_reg1, ex_reg2} !== {1'b1, 32'h1000, 32'hfffffffc}) begin n_err++; $display("FAIL lw got %b/%h/%h exp 1/1000/fffffffc", ex_is_load, ex_reg1, ex_reg2); end
    n_cmp++; if ({ex_aluop, ex_waddr, ex_we} !== {4'd1, 5'd7, 1'b1}) begin n_err++; $display("FAIL lw_dst got %0d/%0d/%b exp 1/7/1", ex_aluop, ex_waddr, ex_we); end
    if_inst = itype(6'h0f, 5'd0, 5'd8, 16'h1234);
    tick;
    n_cmp++; if ({ex_reg1, ex_reg2, ex_aluop, ex_is_load} !== {32'h0, 32'h12340000, 4'd7, 1'b0}) begin n_err++; $display("FAIL lui got %h/%h/%0d/%b exp 0/12340000/7/0", ex_reg1, ex_reg2, ex_aluop, ex_is_load); end
    if_inst = rtype(5'd1, 5'd2, 5'd0, 6'h21);
    tick;
    n_cmp++; if ({ex_valid, ex_we} !== 2'b10) begin n_err++; $display("FAIL dst_r0 got %b%b exp 10", ex_valid, ex_we); end
  endtask

  task automatic test_flush_with_hazard;
    if_inst = rtype(5'd4, 5'd0, 5'd5, 6'h21);
    fwd_ex_we = 1; fwd_ex_waddr = 4; fwd_ex_load = 1; flush = 1;
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL fh_stall got %b exp 1", stall_req); end
    tick;
    n_cmp++; if ({ex_valid, ex_we} !== 2'b00) begin n_err++; $display("FAIL fh_bubble got %b%b exp 00", ex_valid, ex_we); end
    flush = 0; clear_fwd;
  endtask

  task automatic test_reset_mid;
    if_inst = itype(6'h0d, 5'd1, 5'd2, 16'h5);
    tick;
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre got %b exp 1", ex_valid); end
    stall_in = 1;
    #3 rst = 1;
    #1;
    n_cmp++; if ({ex_valid, ex_we, ex_aluop} !== {1'b0, 1'b0, 4'd0}) begin n_err++; $display("FAIL rm_async got %b%b/%0d exp 00/0", ex_valid, ex_we, ex_aluop); end
    tick;
    rst = 0; stall_in = 0; if_valid = 0;
    tick;
    n_cmp++; if ({ex_valid, ex_we} !== 2'b00) begin n_err++; $display("FAIL rm_drop got %b%b exp 00", ex_valid, ex_we); end
  endtask

  initial begin
    rst = 1; if_valid = 0; if_pc = 0; if_inst = 0; rdata1 = 0; rdata2 = 0;
    stall_in = 0; flush = 0;
    clear_fwd;
    test_reset;
    test_ori;
    test_fwd;
    test_load_use;
    test_stall_flush;
    test_illegal;
    test_lw_lui;
    test_flush_with_hazard;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
